// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between inst fetch and load/store, routing responses in issue order.
module sram_port_arbiter #(
  parameter int DEPTH = 4,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inst_req,
  input  logic        i_inst_wr,
  input  logic [1:0]  i_inst_size,
  input  logic [3:0]  i_inst_wstrb,
  input  logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_wdata,
  output logic        o_inst_addr_ok,
  output logic        o_inst_data_ok,
  output logic [31:0] o_inst_rdata,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [1:0]  i_data_size,
  input  logic [3:0]  i_data_wstrb,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic        o_data_addr_ok,
  output logic        o_data_data_ok,
  output logic [31:0] o_data_rdata,
  output logic        o_m_req,
  output logic        o_m_wr,
  output logic [1:0]  o_m_size,
  output logic [3:0]  o_m_wstrb,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic        i_m_addr_ok,
  input  logic        i_m_data_ok,
  input  logic [31:0] i_m_rdata,
  output logic        o_resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);
  logic [DEPTH-1:0] r_fifo;
  logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [SW-1:0]    r_streak;
  logic             r_lock, r_lock_id, r_resp_err;
  logic w_lock_hit, w_starve, w_gnt, w_gnt_data, w_full, w_accept, w_pop, w_head;
  always_comb begin
    w_lock_hit = r_lock && (r_lock_id ? i_data_req : i_inst_req);
    w_starve   = i_inst_req && i_data_req && r_streak == SMAX;
    w_gnt      = i_inst_req || i_data_req;
    w_gnt_data = w_lock_hit ? r_lock_id : w_starve ? 1'b0 : i_data_req;
    w_full     = r_count == CW'(DEPTH);
    w_accept   = o_m_req && i_m_addr_ok;
    w_head     = r_fifo[r_rd_ptr];
    w_pop      = i_m_data_ok && r_count != '0;
  end
  // Request fields read as zero when nobody is granted; full only blocks the handshake.
  assign o_m_req   = w_gnt && !w_full;
  assign o_m_wr    = w_gnt && (w_gnt_data ? i_data_wr : i_inst_wr);
  assign o_m_size  = !w_gnt ? 2'b0  : w_gnt_data ? i_data_size  : i_inst_size;
  assign o_m_wstrb = !w_gnt ? 4'b0  : w_gnt_data ? i_data_wstrb : i_inst_wstrb;
  assign o_m_addr  = !w_gnt ? 32'b0 : w_gnt_data ? i_data_addr  : i_inst_addr;
  assign o_m_wdata = !w_gnt ? 32'b0 : w_gnt_data ? i_data_wdata : i_inst_wdata;
  assign o_inst_addr_ok = w_accept && !w_gnt_data;
  assign o_data_addr_ok = w_accept && w_gnt_data;
  assign o_inst_data_ok = w_pop && !w_head;
  assign o_data_data_ok = w_pop && w_head;
  assign o_inst_rdata   = i_m_rdata;
  assign o_data_rdata   = i_m_rdata;
  assign o_resp_err     = r_resp_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_streak   <= '0;
      r_lock     <= 1'b0;
      r_lock_id  <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_fifo[r_wr_ptr] <= w_gnt_data;
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_accept) - CW'(w_pop);
      if (i_m_data_ok && r_count == '0) r_resp_err <= 1'b1;
      if (w_accept) r_lock <= 1'b0;
      else if (o_m_req) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_gnt_data;
      end else if (!w_lock_hit) r_lock <= 1'b0;
      if (!i_inst_req || o_inst_addr_ok) r_streak <= '0;
      else if (o_data_addr_ok && r_streak != SMAX) r_streak <= r_streak + 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed checks of grant priority, lock, streak limit, FIFO routing, full and error handling.
module tb_sram_port_arbiter;
  logic clk = 0, reset = 1;
  logic i_inst_req, i_inst_wr, i_data_req, i_data_wr, i_m_addr_ok, i_m_data_ok;
  logic [1:0] i_inst_size, i_data_size;
  logic [3:0] i_inst_wstrb, i_data_wstrb;
  logic [31:0] i_inst_addr, i_inst_wdata, i_data_addr, i_data_wdata, i_m_rdata;
  logic o_inst_addr_ok, o_inst_data_ok, o_data_addr_ok, o_data_data_ok, o_m_req, o_m_wr, o_resp_err;
  logic [31:0] o_inst_rdata, o_data_rdata, o_m_addr, o_m_wdata;
  logic [1:0] o_m_size;
  logic [3:0] o_m_wstrb;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  sram_port_arbiter #(.DEPTH(4), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_inst_req(i_inst_req), .i_inst_wr(i_inst_wr), .i_inst_size(i_inst_size), .i_inst_wstrb(i_inst_wstrb),
    .i_inst_addr(i_inst_addr), .i_inst_wdata(i_inst_wdata), .o_inst_addr_ok(o_inst_addr_ok),
    .o_inst_data_ok(o_inst_data_ok), .o_inst_rdata(o_inst_rdata),
    .i_data_req(i_data_req), .i_data_wr(i_data_wr), .i_data_size(i_data_size), .i_data_wstrb(i_data_wstrb),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata), .o_data_addr_ok(o_data_addr_ok),
    .o_data_data_ok(o_data_data_ok), .o_data_rdata(o_data_rdata),
    .o_m_req(o_m_req), .o_m_wr(o_m_wr), .o_m_size(o_m_size), .o_m_wstrb(o_m_wstrb), .o_m_addr(o_m_addr),
    .o_m_wdata(o_m_wdata), .i_m_addr_ok(i_m_addr_ok), .i_m_data_ok(i_m_data_ok), .i_m_rdata(i_m_rdata),
    .o_resp_err(o_resp_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    i_inst_req = 0; i_inst_wr = 0; i_inst_size = 2'd2; i_inst_wstrb = 4'hf; i_inst_addr = 0; i_inst_wdata = 0;
    i_data_req = 0; i_data_wr = 0; i_data_size = 2'd2; i_data_wstrb = 4'hf; i_data_addr = 0; i_data_wdata = 0;
    i_m_addr_ok = 0; i_m_data_ok = 0; i_m_rdata = 0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #2;
  endtask
  initial begin
    logic [9:0] pat;
    logic prev;
    idle();
    step(); step();
    reset = 0;
    settle();
    chk("rst_inst_addr_ok", o_inst_addr_ok, 0);
    chk("rst_data_addr_ok", o_data_addr_ok, 0);
    chk("rst_data_oks", {o_inst_data_ok, o_data_data_ok}, 0);
    chk("rst_m_req", o_m_req, 0);
    chk("rst_m_addr", o_m_addr, 0);
    chk("rst_resp_err", o_resp_err, 0);
    chk("rst_count", dut.r_count, 0);
    // single inst read
    step();
    i_inst_req = 1; i_inst_addr = 32'h1c000000; i_m_addr_ok = 1;
    settle();
    chk("s_inst_addr_ok", o_inst_addr_ok, 1);
    chk("s_data_addr_ok", o_data_addr_ok, 0);
    chk("s_m_addr", o_m_addr, 32'h1c000000);
    step(); idle(); settle();
    chk("s_idle_m_req", o_m_req, 0);
    step();
    i_m_data_ok = 1; i_m_rdata = 32'h02800c0c;
    settle();
    chk("s_inst_data_ok", o_inst_data_ok, 1);
    chk("s_inst_rdata", o_inst_rdata, 32'h02800c0c);
    chk("s_data_data_ok", o_data_data_ok, 0);
    step(); idle();
    // contention: expected grant order D,D,D,D,I,D,D,D,D,I (bit i = data granted in cycle i)
    pat = 10'b0111101111;
    prev = 0;
    for (int i = 0; i < 10; i++) begin
      i_inst_req = 1; i_data_req = 1; i_m_addr_ok = 1; i_m_data_ok = prev;
      i_inst_addr = 32'h100 + i; i_data_addr = 32'h200 + i; i_m_rdata = 32'h5000 + i;
      settle();
      chk($sformatf("c_data_addr_ok%0d", i), o_data_addr_ok, pat[i]);
      chk($sformatf("c_inst_addr_ok%0d", i), o_inst_addr_ok, !pat[i]);
      chk($sformatf("c_m_addr%0d", i), o_m_addr, pat[i] ? 32'h200 + i : 32'h100 + i);
      if (i > 0) chk($sformatf("c_resp%0d", i), {o_inst_data_ok, o_data_data_ok}, pat[i-1] ? 2'b01 : 2'b10);
      prev = 1;
      step();
    end
    idle(); i_m_data_ok = 1;
    settle();
    chk("c_last_resp", {o_inst_data_ok, o_data_data_ok}, 2'b10);
    step(); idle(); settle();
    chk("c_count", dut.r_count, 0);
    // lock: data stalls three cycles, inst arrives in cycle 1
    i_data_req = 1; i_data_addr = 32'ha0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin i_inst_req = 1; i_inst_addr = 32'h10; end
      settle();
      chk($sformatf("l_m_addr%0d", i), o_m_addr, 32'ha0);
      chk($sformatf("l_addr_ok%0d", i), {o_inst_addr_ok, o_data_addr_ok}, 0);
      step();
    end
    i_m_addr_ok = 1;
    settle();
    chk("l_data_accept", {o_inst_addr_ok, o_data_addr_ok}, 2'b01);
    chk("l_m_addr3", o_m_addr, 32'ha0);
    step();
    i_data_req = 0;
    settle();
    chk("l_inst_accept", {o_inst_addr_ok, o_data_addr_ok}, 2'b10);
    chk("l_m_addr4", o_m_addr, 32'h10);
    step(); idle(); i_m_data_ok = 1; settle();
    chk("l_resp0", {o_inst_data_ok, o_data_data_ok}, 2'b01);
    step(); settle();
    chk("l_resp1", {o_inst_data_ok, o_data_data_ok}, 2'b10);
    step(); idle(); settle();
    chk("l_count", dut.r_count, 0);
    // full: four inst accepts with no responses
    i_inst_req = 1; i_m_addr_ok = 1;
    for (int i = 0; i < 8; i++) begin
      i_m_data_ok = (i == 6);
      settle();
      chk($sformatf("f_m_req%0d", i), o_m_req, (i < 4 || i == 7));
      chk($sformatf("f_addr_ok%0d", i), o_inst_addr_ok, (i < 4 || i == 7));
      chk($sformatf("f_data_ok%0d", i), o_inst_data_ok, (i == 6));
      step();
    end
    idle(); i_m_data_ok = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk($sformatf("f_drain%0d", i), o_inst_data_ok, 1);
      step();
    end
    idle(); settle();
    chk("f_count", dut.r_count, 0);
    // interleaved I,D,I
    i_m_addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      i_inst_req = (i != 1); i_data_req = (i == 1);
      settle();
      chk($sformatf("i_accept%0d", i), {o_inst_addr_ok, o_data_addr_ok}, (i == 1) ? 2'b01 : 2'b10);
      step();
    end
    idle(); i_m_data_ok = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("i_resp%0d", i), {o_inst_data_ok, o_data_data_ok}, (i == 1) ? 2'b01 : 2'b10);
      step();
    end
    idle(); settle();
    chk("i_count", dut.r_count, 0);
    chk("i_resp_err", o_resp_err, 0);
    // error on empty response, then reset with two outstanding
    i_m_data_ok = 1;
    settle();
    chk("e_data_oks", {o_inst_data_ok, o_data_data_ok}, 0);
    step(); idle(); settle();
    chk("e_resp_err", o_resp_err, 1);
    chk("e_count", dut.r_count, 0);
    i_inst_req = 1; i_m_addr_ok = 1;
    step(); step(); idle(); settle();
    chk("e_outstanding", dut.r_count, 2);
    reset = 1;
    step();
    reset = 0;
    settle();
    chk("e_rst_count", dut.r_count, 0);
    chk("e_rst_resp_err", o_resp_err, 0);
    i_m_data_ok = 1;
    settle();
    chk("e_post_rst_data_oks", {o_inst_data_ok, o_data_data_ok}, 0);
    step(); idle(); settle();
    chk("e_post_rst_err", o_resp_err, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (inst side) and the load/store requester (data side).
- Sits between the IF/MEM stages and the single downstream SRAM-like/bridge port.
- Arbitrates address-phase requests using data priority with a bounded-starvation guarantee for fetch.
- Tracks outstanding transactions in an in-order ID FIFO and routes each data_ok/rdata back to the requester that issued it.

Parameters:
- DEPTH, 4: maximum outstanding (addr-accepted, data not yet returned) transactions; power of two, 2..16.
- MAX_DATA_STREAK, 4: maximum consecutive data grants while inst_req is pending before inst is forced a grant.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req / data_req  in  1  requester request valid
- inst_wr / data_wr  in  1  write enable
- inst_size / data_size  in  2  access size
- inst_wstrb / data_wstrb  in  4  byte strobes
- inst_addr / data_addr  in  32  address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  address phase accepted this cycle
- inst_data_ok / data_data_ok  out  1  response returned this cycle
- inst_rdata / data_rdata  out  32  read data (both driven from m_rdata)
- m_req  out  1  to memory: request valid
- m_wr  out  1  write enable
- m_size  out  2  access size
- m_wstrb  out  4  byte strobes
- m_addr  out  32  address
- m_wdata  out  32  write data
- m_addr_ok  in  1  memory: address accepted
- m_data_ok  in  1  memory: response valid
- m_rdata  in  32  memory: read data
- resp_err  out  1  sticky: m_data_ok received with ID FIFO empty

Behaviour:
- Reset: FIFO empty (rd/wr pointers 0, count 0), streak counter 0, lock cleared, resp_err 0. All *_addr_ok and *_data_ok are 0 while the FIFO is empty and no request is present.
- Grant is combinational each cycle, in this priority order:
  1. Lock: lock set and the locked master still requests -> grant the locked master.
  2. Starvation: inst_req && data_req && streak == MAX_DATA_STREAK -> grant inst.
  3. data_req -> grant data.
  4. inst_req -> grant inst.
  5. Otherwise no grant.
- m_req = granted && !fifo_full. The m_* request fields mux from the granted master; they are zero when no grant.
- Address handshake (accept): m_req && m_addr_ok. On accept:
  - Pulse the granted master's addr_ok in the same cycle; the other master's addr_ok stays 0.
  - Push the master ID into the FIFO (0 = inst, 1 = data).
- Lock: set when m_req && !m_addr_ok, recording the grantee; cleared on accept, or when the locked master drops req.
- Streak counter update:
  - Data accepted while inst_req high -> streak+1, saturating at MAX_DATA_STREAK.
  - Inst accepted, or inst_req low -> streak 0.
- Response routing: on m_data_ok with FIFO non-empty, pop the head.
  - inst_data_ok = m_data_ok && head == 0.
  - data_data_ok = m_data_ok && head == 1.
  - rdata is passed through combinationally; zero added latency.
- m_data_ok with FIFO empty: no data_ok to either master, no pop, resp_err <= 1 (cleared only by reset).
- Full: count == DEPTH forces m_req = 0 and both addr_ok = 0. This holds even if m_data_ok pops in the same cycle, so there is no push-while-full.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.
- Responses are assumed in-order from memory; responses are never reordered.
- Reset mid-transaction discards all outstanding IDs; responses arriving after reset are handled as the FIFO-empty case.

Test Plan:
- Single inst read: inst_req=1, addr=0x1c000000, m_addr_ok=1 in cycle 0, m_data_ok=1 with rdata=0x02800c0c in cycle 2 -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 and inst_rdata=0x02800c0c in cycle 2; data_data_ok stays 0.
- Contention: inst_req and data_req both held, m_addr_ok=1 every cycle, MAX_DATA_STREAK=4, responses returning -> grant pattern D,D,D,D,I,D,D,D,D,I; data_data_ok/inst_data_ok follow the same order.
- Lock: data_req=1 with m_addr_ok=0 for 3 cycles, inst_req raised in cycle 1 -> m_addr stays data_addr for all 3 cycles; data accepted in cycle 3; inst granted in cycle 4.
- Full: DEPTH=4, 4 inst accepts with no m_data_ok -> m_req=0 and inst_addr_ok=0 in cycle 4. Then m_data_ok in cycle 6 -> inst_data_ok=1 in cycle 6; m_req reasserts in cycle 7.
- Interleaved order: accept sequence I,D,I, then three m_data_ok pulses -> inst_data_ok, data_data_ok, inst_data_ok in that order; count returns to 0.
- Error and reset: m_data_ok with FIFO empty -> both data_ok 0 and resp_err=1. Assert reset with 2 transactions outstanding -> count=0 and resp_err=0 the next cycle.
